// File: rtl/mem_sched_pkg.sv
// Shared types for the round-robin memory scheduler: FSM states, the
// request/response payloads and the index-width helper.
package mem_sched_pkg;

    typedef enum logic {ARB, HOLD} sched_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mresp_t;

    // A single master still needs one bit to name itself.
    function automatic int idx_w(input int cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

endpackage

// File: rtl/index_fifo.sv
// Small FIFO of master indices; in fall-through mode an entry pushed this
// cycle is visible at the head (and may be popped) in the same cycle.
module index_fifo #(
    parameter int DEPTH       = 4,
    parameter int WIDTH       = 2,
    parameter int FALLTHROUGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
    logic [CNT_W-1:0] count;
    logic             stored_empty, bypass, do_write, do_read;

    assign stored_empty = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign bypass       = (FALLTHROUGH != 0) && stored_empty && push;
    assign empty        = stored_empty && !bypass;
    assign pop_data     = stored_empty ? push_data : mem[rd_ptr];

    // A push consumed by a same-cycle pop on an empty FIFO never gets stored.
    assign do_write = push && !full && !(bypass && pop);
    assign do_read  = pop && !stored_empty;

    assign rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr_inc;
            if (do_read)  rd_ptr <= rd_ptr_inc;
            if (do_write && !do_read) count <= count + 1'b1;
            else if (do_read && !do_write) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rr_select.sv
// Round-robin pick: the first eligible requester after 'last', wrapping
// around so that 'last' itself has the lowest priority.
module rr_select
    import mem_sched_pkg::*;
#(
    parameter int CNT   = 3,
    parameter int IDX_W = idx_w(CNT)
) (
    input  logic [CNT-1:0]   eligible,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W:0] cand;

    // last < CNT and the offset is <= CNT, so one subtraction always wraps.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < CNT; k++) begin
            cand = {1'b0, last} + (IDX_W+1)'(k + 1);
            if (cand >= (IDX_W+1)'(CNT)) begin
                cand = cand - (IDX_W+1)'(CNT);
            end
            if (!any && eligible[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Shares one memory slave port among CNT masters with round-robin grants,
// per-master outstanding limits and in-order response routing.
module mem_rr_scheduler
    import mem_sched_pkg::*;
#(
    parameter int CNT             = 3,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT-1:0]      master_req_valid,
    output logic [CNT-1:0]      master_req_ready,
    input  mreq_t [CNT-1:0]     master_req_data,
    output logic [CNT-1:0]      master_resp_valid,
    input  logic [CNT-1:0]      master_resp_ready,
    output mresp_t [CNT-1:0]    master_resp_data,
    output logic                slave_req_valid,
    input  logic                slave_req_ready,
    output mreq_t               slave_req_data,
    input  logic                slave_resp_valid,
    output logic                slave_resp_ready,
    input  mresp_t              slave_resp_data,
    output logic                idle
);

    localparam int IDX_W = idx_w(CNT);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    sched_state_e     state, state_n;
    logic [IDX_W-1:0] hold_idx, hold_idx_n, last, sel, rr_winner, head;
    logic [CNT-1:0]   eligible, cnt_inc, cnt_dec;
    logic [CNT_W-1:0] out_cnt [CNT];
    logic             rr_any, req_fire, resp_fire, fifo_full, fifo_empty;

    always_comb begin
        for (int i = 0; i < CNT; i++) begin
            eligible[i] = master_req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_select #(.CNT(CNT), .IDX_W(IDX_W)) u_rr_select (
        .eligible (eligible),
        .last     (last),
        .winner   (rr_winner),
        .any      (rr_any)
    );

    // HOLD pins the stalled grant so the slave sees a stable request until it fires.
    always_comb begin
        state_n         = state;
        hold_idx_n      = hold_idx;
        sel             = rr_winner;
        slave_req_valid = 1'b0;
        case (state)
            ARB: begin
                slave_req_valid = rr_any && !fifo_full && !rst;
                if (slave_req_valid && !slave_req_ready) begin
                    state_n    = HOLD;
                    hold_idx_n = rr_winner;
                end
            end
            HOLD: begin
                sel             = hold_idx;
                slave_req_valid = !fifo_full && !rst;
                if (slave_req_valid && slave_req_ready) state_n = ARB;
            end
            default: state_n = ARB;
        endcase
    end

    assign req_fire         = slave_req_valid && slave_req_ready;
    assign slave_req_data   = master_req_data[sel];
    assign slave_resp_ready = !fifo_empty && master_resp_ready[head] && !rst;
    assign resp_fire        = slave_resp_valid && slave_resp_ready;
    assign idle             = fifo_empty && !slave_req_valid;

    always_comb begin
        for (int i = 0; i < CNT; i++) begin
            master_req_ready[i]  = req_fire && (sel == IDX_W'(i));
            master_resp_valid[i] = slave_resp_valid && !fifo_empty && (head == IDX_W'(i)) && !rst;
            master_resp_data[i]  = slave_resp_data;
            cnt_inc[i]           = req_fire && (sel == IDX_W'(i));
            cnt_dec[i]           = resp_fire && (head == IDX_W'(i));
        end
    end

    index_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(IDX_W), .FALLTHROUGH(1)) u_index_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (sel),
        .pop       (resp_fire),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue and retire for the same master in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            hold_idx <= '0;
            last     <= IDX_W'(CNT - 1);
            for (int i = 0; i < CNT; i++) out_cnt[i] <= '0;
        end else begin
            state    <= state_n;
            hold_idx <= hold_idx_n;
            if (req_fire) last <= sel;
            for (int i = 0; i < CNT; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) out_cnt[i] <= out_cnt[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i]) out_cnt[i] <= out_cnt[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Scenario bench for mem_rr_scheduler: masters, an in-order slave model and a
// response scoreboard advanced one clock per apply_stimulus call.
module tb_mem_rr_scheduler;
    import mem_sched_pkg::*;

    localparam int CNT = 3;

    logic clk = 1'b0;
    logic rst;
    logic [CNT-1:0] master_req_valid, master_req_ready, master_resp_valid, master_resp_ready;
    mreq_t [CNT-1:0]  master_req_data;
    mresp_t [CNT-1:0] master_resp_data;
    logic   slave_req_valid, slave_req_ready, slave_resp_valid, slave_resp_ready, idle;
    mreq_t  slave_req_data;
    mresp_t slave_resp_data;

    mem_rr_scheduler #(.CNT(CNT), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .master_req_valid  (master_req_valid),
        .master_req_ready  (master_req_ready),
        .master_req_data   (master_req_data),
        .master_resp_valid (master_resp_valid),
        .master_resp_ready (master_resp_ready),
        .master_resp_data  (master_resp_data),
        .slave_req_valid   (slave_req_valid),
        .slave_req_ready   (slave_req_ready),
        .slave_req_data    (slave_req_data),
        .slave_resp_valid  (slave_resp_valid),
        .slave_resp_ready  (slave_resp_ready),
        .slave_resp_data   (slave_resp_data),
        .idle              (idle)
    );

    always #5 clk = ~clk;

    typedef struct {int m; logic [31:0] rdata;} exp_t;
    typedef struct {logic [31:0] addr; int cyc;} inflight_t;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int pending [CNT];
    int seq [CNT];
    logic [CNT-1:0] resp_rdy;
    logic resp_enable, slv_ready;
    int resp_delay;
    exp_t sb [$];
    inflight_t slv_q [$];
    int grant_log [$];

    logic obs_req_valid, obs_req_fire, obs_sresp_ready, obs_resp_fire;
    int obs_req_master;
    logic [CNT-1:0] obs_resp_valid;

    function automatic logic pending_any();
        for (int i = 0; i < CNT; i++) if (pending[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive masters and slave model, check the cycle, then advance.
    task automatic apply_stimulus();
        int head_m, fire_m;
        logic exp_rdy;
        logic [CNT-1:0] exp_valid;
        logic [31:0] a;
        for (int i = 0; i < CNT; i++) begin
            master_req_valid[i]      = pending[i] > 0;
            master_req_data[i].addr  = {i[3:0], seq[i][27:0]};
            master_req_data[i].we    = 1'b0;
            master_req_data[i].wdata = seq[i];
        end
        master_resp_ready = resp_rdy;
        slave_req_ready   = slv_ready;
        if (resp_enable && slv_q.size() > 0 && cyc >= slv_q[0].cyc + resp_delay) begin
            slave_resp_valid      = 1'b1;
            slave_resp_data.rdata = ~slv_q[0].addr;
        end else begin
            slave_resp_valid      = 1'b0;
            slave_resp_data.rdata = 32'hdead_beef;
        end
        #2;
        obs_req_valid   = slave_req_valid;
        obs_req_master  = int'(slave_req_data.addr[31:28]);
        obs_req_fire    = slave_req_valid && slave_req_ready;
        obs_sresp_ready = slave_resp_ready;
        obs_resp_fire   = slave_resp_valid && slave_resp_ready;
        obs_resp_valid  = master_resp_valid;
        if (rst) begin
            tests_run++;
            if ({slave_req_valid, slave_resp_ready, master_req_ready, master_resp_valid} !== '0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs: got %0h expected 0",
                         {slave_req_valid, slave_resp_ready, master_req_ready, master_resp_valid});
            end
        end else begin
            fire_m = -1;
            tests_run++;
            if (obs_req_fire) begin
                fire_m = obs_req_master;
                if (master_req_ready !== (CNT'(1) << fire_m)) begin
                    tests_failed++;
                    $display("[TB] FAIL req_ready: got %b expected %b", master_req_ready, CNT'(1) << fire_m);
                end
            end else if (master_req_ready !== '0) begin
                tests_failed++;
                $display("[TB] FAIL req_ready_idle: got %b expected 0", master_req_ready);
            end
            head_m = (sb.size() > 0) ? sb[0].m : fire_m;
            exp_rdy = (head_m >= 0 && head_m < CNT) ? resp_rdy[head_m] : 1'b0;
            tests_run++;
            if (slave_resp_ready !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL slave_resp_ready: got %b expected %b", slave_resp_ready, exp_rdy);
            end
            exp_valid = (slave_resp_valid && head_m >= 0 && head_m < CNT) ? (CNT'(1) << head_m) : '0;
            tests_run++;
            if (master_resp_valid !== exp_valid) begin
                tests_failed++;
                $display("[TB] FAIL resp_valid: got %b expected %b", master_resp_valid, exp_valid);
            end
            if (obs_resp_fire) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL resp_unexpected: got response expected none");
                end else begin
                    if (master_resp_data[sb[0].m].rdata !== sb[0].rdata) begin
                        tests_failed++;
                        $display("[TB] FAIL resp_data: got %h expected %h",
                                 master_resp_data[sb[0].m].rdata, sb[0].rdata);
                    end
                    void'(sb.pop_front());
                end
                if (slv_q.size() > 0) void'(slv_q.pop_front());
            end
            if (obs_req_fire && fire_m >= 0 && fire_m < CNT) begin
                pending[fire_m]--;
                seq[fire_m]++;
                grant_log.push_back(fire_m);
                a = slave_req_data.addr;
                sb.push_back('{fire_m, ~a});
                slv_q.push_back('{a, cyc});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        resp_enable = 1'b1;
        slv_ready   = 1'b1;
        resp_rdy    = '1;
        while ((pending_any() || sb.size() > 0) && n < 100) begin
            apply_stimulus();
            n++;
        end
        tests_run++;
        if (pending_any() || sb.size() > 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_drain: got %0d outstanding expected 0", name, sb.size());
        end
        master_req_valid = '0;
        slave_resp_valid = 1'b0;
        #1;
        tests_run++;
        if (idle !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_idle: got %b expected 1", name, idle);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < CNT; i++) pending[i] = 1;
        apply_stimulus();
        apply_stimulus();
        rst = 1'b0;
        for (int i = 0; i < CNT; i++) pending[i] = 0;
        master_req_valid = '0;
        #1;
        tests_run++;
        if (idle !== 1'b1 || slave_req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got idle=%b valid=%b expected idle=1 valid=0", idle, slave_req_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_g [6] = '{0, 1, 2, 0, 1, 2};
        grant_log.delete();
        for (int i = 0; i < CNT; i++) pending[i] = 2;
        resp_delay = 2;
        for (int i = 0; i < 6; i++) apply_stimulus();
        drain("round_robin");
        tests_run++;
        if (grant_log.size() != 6) begin
            tests_failed++;
            $display("[TB] FAIL rr_count: got %0d expected 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (grant_log[i] != exp_g[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_hold_stability();
        resp_delay = 1;
        slv_ready  = 1'b0;
        pending[1] = 1;
        for (int t = 0; t < 3; t++) begin
            apply_stimulus();
            pending[0] = 1;
            tests_run++;
            if (obs_req_valid !== 1'b1 || obs_req_master != 1) begin
                tests_failed++;
                $display("[TB] FAIL hold_data[%0d]: got valid=%b master=%0d expected valid=1 master=1",
                         t, obs_req_valid, obs_req_master);
            end
        end
        slv_ready = 1'b1;
        apply_stimulus();
        tests_run++;
        if (!obs_req_fire || obs_req_master != 1) begin
            tests_failed++;
            $display("[TB] FAIL hold_first_fire: got fire=%b master=%0d expected fire=1 master=1",
                     obs_req_fire, obs_req_master);
        end
        apply_stimulus();
        tests_run++;
        if (!obs_req_fire || obs_req_master != 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_second_fire: got fire=%b master=%0d expected fire=1 master=0",
                     obs_req_fire, obs_req_master);
        end
        drain("hold");
    endtask

    task automatic test_outstanding_limit();
        int fires = 0;
        resp_enable = 1'b0;
        resp_delay  = 0;
        pending[0]  = 5;
        for (int t = 0; t < 4; t++) begin
            apply_stimulus();
            if (obs_req_fire) fires++;
        end
        tests_run++;
        if (fires != 2 || obs_req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL limit_m0: got fires=%0d valid=%b expected fires=2 valid=0", fires, obs_req_valid);
        end
        fires = 0;
        pending[2] = 5;
        for (int t = 0; t < 4; t++) begin
            apply_stimulus();
            if (obs_req_fire) fires++;
        end
        tests_run++;
        if (fires != 2) begin
            tests_failed++;
            $display("[TB] FAIL limit_m2: got fires=%0d expected 2", fires);
        end
        pending[1] = 1;
        for (int t = 0; t < 2; t++) begin
            apply_stimulus();
            tests_run++;
            if (obs_req_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL fifo_full_valid[%0d]: got %b expected 0", t, obs_req_valid);
            end
        end
        drain("limit");
    endtask

    task automatic test_same_cycle_fire();
        resp_delay = 1;
        pending[2] = 4;
        apply_stimulus();
        apply_stimulus();
        tests_run++;
        if (!obs_req_fire || obs_req_master != 2 || !obs_resp_fire || obs_resp_valid !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle: got req=%b m=%0d resp=%b rv=%b expected req=1 m=2 resp=1 rv=100",
                     obs_req_fire, obs_req_master, obs_resp_fire, obs_resp_valid);
        end
        resp_enable = 1'b0;
        apply_stimulus();
        tests_run++;
        if (!obs_req_fire) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_cnt1: got fire=%b expected 1", obs_req_fire);
        end
        apply_stimulus();
        tests_run++;
        if (obs_req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_cnt2: got valid=%b expected 0", obs_req_valid);
        end
        drain("same_cycle");
    endtask

    task automatic test_resp_backpressure();
        int fires = 0;
        resp_delay = 1;
        resp_rdy   = 3'b101;
        pending[1] = 1;
        apply_stimulus();
        pending[0] = 2;
        pending[2] = 2;
        for (int t = 0; t < 4; t++) begin
            apply_stimulus();
            if (obs_req_fire) fires++;
            tests_run++;
            if (obs_sresp_ready !== 1'b0 || obs_resp_valid !== 3'b010) begin
                tests_failed++;
                $display("[TB] FAIL backpressure[%0d]: got ready=%b rv=%b expected ready=0 rv=010",
                         t, obs_sresp_ready, obs_resp_valid);
            end
        end
        tests_run++;
        if (fires != 3 || obs_req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_issue: got fires=%0d valid=%b expected fires=3 valid=0",
                     fires, obs_req_valid);
        end
        drain("backpressure");
    endtask

    task automatic test_reset_midflight();
        int exp_g [4] = '{0, 1, 2, 0};
        resp_enable = 1'b0;
        for (int i = 0; i < CNT; i++) pending[i] = 1;
        for (int t = 0; t < 3; t++) apply_stimulus();
        pending[0] = 1;
        slv_ready  = 1'b0;
        apply_stimulus();
        tests_run++;
        if (obs_req_valid !== 1'b1 || obs_req_master != 0) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_hold: got valid=%b m=%0d expected valid=1 m=0", obs_req_valid, obs_req_master);
        end
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        sb.delete();
        slv_q.delete();
        for (int i = 0; i < CNT; i++) pending[i] = 0;
        master_req_valid = '0;
        #1;
        tests_run++;
        if (idle !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got %b expected 1", idle);
        end
        grant_log.delete();
        pending[0] = 2;
        pending[1] = 1;
        pending[2] = 1;
        slv_ready  = 1'b1;
        for (int t = 0; t < 4; t++) apply_stimulus();
        tests_run++;
        if (grant_log.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_count: got %0d expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant_log[i] != exp_g[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL post_reset_order[%0d]: got %0d expected %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
        drain("reset_midflight");
    endtask

    initial begin
        rst               = 1'b1;
        master_req_valid  = '0;
        master_req_data   = '0;
        master_resp_ready = '0;
        slave_req_ready   = 1'b0;
        slave_resp_valid  = 1'b0;
        slave_resp_data   = '0;
        resp_rdy          = '1;
        resp_enable       = 1'b1;
        resp_delay        = 2;
        slv_ready         = 1'b1;
        for (int i = 0; i < CNT; i++) begin
            pending[i] = 0;
            seq[i]     = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_hold_stability();
        test_outstanding_limit();
        test_same_cycle_fire();
        test_resp_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
